// File: rtl/fpu_dp_pkg.sv
// -----------------------------------------------------------------------------
// fpu_dp_pkg
// Shared constants and types for the double-precision result path.
//   DP_EXP_W / DP_MANT_W / DP_EXP_MAX : binary64 field geometry
//   FLAG_OVF / FLAG_UNF / FLAG_INV    : bit positions inside dp_flags_t
// -----------------------------------------------------------------------------
package fpu_dp_pkg;
    localparam int             DP_EXP_W   = 11;
    localparam int             DP_MANT_W  = 52;
    localparam logic [10:0]    DP_EXP_MAX = 11'h7FF;

    localparam int             FLAG_OVF   = 0;
    localparam int             FLAG_UNF   = 1;
    localparam int             FLAG_INV   = 2;

    typedef logic [2:0] dp_flags_t;
endpackage

// File: rtl/fpu_dp_fixup.sv
// -----------------------------------------------------------------------------
// fpu_dp_fixup
// Combinational IEEE-754 special-value substitution for the adder result.
// Ports:
//   i_result    [63:0] packed {sign, exp, mant} from the adder
//   i_overflow         adder overflow
//   i_underflow        adder underflow
//   o_result    [63:0] substituted result
//   o_flags     [2:0]  {invalid, underflow, overflow}
// Priority: overflow -> +/-Inf, else underflow -> +/-0, else NaN flagged
// invalid and passed through, else plain pass-through.
// -----------------------------------------------------------------------------
module fpu_dp_fixup
    import fpu_dp_pkg::*;
(
    input  logic [63:0] i_result,
    input  logic        i_overflow,
    input  logic        i_underflow,
    output logic [63:0] o_result,
    output dp_flags_t   o_flags
);

    logic                 w_sign;
    logic [DP_EXP_W-1:0]  w_exp;
    logic [DP_MANT_W-1:0] w_mant;

    assign w_sign = i_result[63];
    assign w_exp  = i_result[62:DP_MANT_W];
    assign w_mant = i_result[DP_MANT_W-1:0];

    always_comb begin
        o_result = i_result;
        o_flags  = '0;
        if (i_overflow) begin
            o_result          = {w_sign, DP_EXP_MAX, {DP_MANT_W{1'b0}}};
            o_flags[FLAG_OVF] = 1'b1;
            // A simultaneous underflow is still reported, but Inf is the value.
            o_flags[FLAG_UNF] = i_underflow;
        end else if (i_underflow) begin
            o_result          = {w_sign, 63'h0};
            o_flags[FLAG_UNF] = 1'b1;
        end else if ((w_exp == DP_EXP_MAX) && (w_mant != '0)) begin
            o_flags[FLAG_INV] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_dp_result_stage.sv
// -----------------------------------------------------------------------------
// fpu_dp_result_stage
// Registered output stage behind the double-precision adder: special-value
// fix-up, a DEPTH-entry FIFO with valid/ready on both sides, and sticky
// exception flags for software.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            producer handshake
//   in_result, in_overflow,
//   in_underflow                 adder result and flags
//   out_valid/out_ready          consumer handshake
//   out_result, out_flags        head entry ({invalid, underflow, overflow})
//   sticky_flags, flags_clear    accumulated flags and their clear pulse
// Optional (macro FPU_RESULT_STATS_EN):
//   ovf_count, unf_count, inv_count  saturating per-flag push counters
// -----------------------------------------------------------------------------
module fpu_dp_result_stage
    import fpu_dp_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_result,
    input  logic        in_overflow,
    input  logic        in_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [2:0]  out_flags,
    output logic [2:0]  sticky_flags,
    input  logic        flags_clear
`ifdef FPU_RESULT_STATS_EN
    ,
    output logic [15:0] ovf_count,
    output logic [15:0] unf_count,
    output logic [15:0] inv_count
`endif
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [63:0]     r_mem_result [DEPTH];
    dp_flags_t       r_mem_flags  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    dp_flags_t        r_sticky;

    logic [63:0]     w_fix_result;
    dp_flags_t       w_fix_flags;
    logic            w_push;
    logic            w_pop;

    fpu_dp_fixup u_fixup (
        .i_result    (in_result),
        .i_overflow  (in_overflow),
        .i_underflow (in_underflow),
        .o_result    (w_fix_result),
        .o_flags     (w_fix_flags)
    );

    // Both readies depend only on registered count, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (r_count != CNT_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Storage is not reset, so mask the head while empty to keep outputs
    // at zero out of reset.
    assign out_result   = out_valid ? r_mem_result[r_rd_ptr] : 64'h0;
    assign out_flags    = out_valid ? r_mem_flags[r_rd_ptr]  : 3'b000;
    assign sticky_flags = r_sticky;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr] <= w_fix_result;
            r_mem_flags[r_wr_ptr]  <= w_fix_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sticky <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // Clear first, then OR in the pushed flags so a same-cycle set wins.
            r_sticky <= (flags_clear ? 3'b000 : r_sticky)
                      | (w_push ? w_fix_flags : 3'b000);
        end
    end

`ifdef FPU_RESULT_STATS_EN
    logic [15:0] r_ovf_count;
    logic [15:0] r_unf_count;
    logic [15:0] r_inv_count;

    function automatic logic [15:0] stat_next(input logic [15:0] cur,
                                              input logic        clr,
                                              input logic        inc);
        logic [15:0] base;
        base = clr ? 16'h0 : cur;
        if (inc && (base != 16'hFFFF)) base = base + 16'h1;
        return base;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
            r_unf_count <= '0;
            r_inv_count <= '0;
        end else begin
            r_ovf_count <= stat_next(r_ovf_count, flags_clear, w_push & w_fix_flags[FLAG_OVF]);
            r_unf_count <= stat_next(r_unf_count, flags_clear, w_push & w_fix_flags[FLAG_UNF]);
            r_inv_count <= stat_next(r_inv_count, flags_clear, w_push & w_fix_flags[FLAG_INV]);
        end
    end

    assign ovf_count = r_ovf_count;
    assign unf_count = r_unf_count;
    assign inv_count = r_inv_count;
`endif

endmodule

// File: tb/tb_fpu_dp_result_stage.sv
// -----------------------------------------------------------------------------
// tb_fpu_dp_result_stage
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the result stage.
// -----------------------------------------------------------------------------
module tb_fpu_dp_result_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [2:0]  out_flags;
    logic [2:0]  sticky_flags;
    logic        flags_clear;
`ifdef FPU_RESULT_STATS_EN
    logic [15:0] ovf_count, unf_count, inv_count;
`endif

    fpu_dp_result_stage #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .flags_clear  (flags_clear)
`ifdef FPU_RESULT_STATS_EN
        ,
        .ovf_count    (ovf_count),
        .unf_count    (unf_count),
        .inv_count    (inv_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic [2:0]  flags;
    } entry_t;

    entry_t      q[$];
    logic [2:0]  m_sticky;
    int          n_checks = 0;
    int          n_errors = 0;
`ifdef FPU_RESULT_STATS_EN
    int          m_ovf, m_unf, m_inv;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference fix-up derived straight from the IEEE field rules.
    task automatic ref_fix(input logic [63:0] res, input logic ovf, input logic unf,
                           output entry_t e);
        longint unsigned exp_f, mant_f, sign_f;
        sign_f = res >> 63;
        exp_f  = (res >> 52) & 64'h7FF;
        mant_f = res & ((64'h1 << 52) - 1);
        e.flags = 3'b000;
        e.result = res;
        if (ovf) begin
            e.result = (sign_f << 63) | (64'h7FF << 52);
            e.flags  = unf ? 3'b011 : 3'b001;
        end else if (unf) begin
            e.result = sign_f << 63;
            e.flags  = 3'b010;
        end else if (exp_f == 64'h7FF && mant_f != 0) begin
            e.flags = 3'b100;
        end
    endtask

    // One clock of traffic: drive, check current outputs, advance model.
    task automatic cycle(input logic v, input logic [63:0] res, input logic ovf,
                         input logic unf, input logic ordy, input logic clr);
        entry_t e;
        logic   exp_ready, push, pop;
        in_valid     = v;
        in_result    = res;
        in_overflow  = ovf;
        in_underflow = unf;
        out_ready    = ordy;
        flags_clear  = clr;
        #1;
        exp_ready = (q.size() != DEPTH);
        chk("in_ready", {63'h0, in_ready}, {63'h0, exp_ready});
        chk("out_valid", {63'h0, out_valid}, {63'h0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_result", out_result, q[0].result);
            chk("out_flags", {61'h0, out_flags}, {61'h0, q[0].flags});
        end
        push = v && exp_ready;
        pop  = (q.size() != 0) && ordy;
        ref_fix(res, ovf, unf, e);
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
        m_sticky = (clr ? 3'b000 : m_sticky) | (push ? e.flags : 3'b000);
        chk("sticky_flags", {61'h0, sticky_flags}, {61'h0, m_sticky});
`ifdef FPU_RESULT_STATS_EN
        if (clr) begin m_ovf = 0; m_unf = 0; m_inv = 0; end
        if (push && e.flags[0] && m_ovf < 65535) m_ovf++;
        if (push && e.flags[1] && m_unf < 65535) m_unf++;
        if (push && e.flags[2] && m_inv < 65535) m_inv++;
        chk("ovf_count", {48'h0, ovf_count}, 64'(m_ovf));
        chk("unf_count", {48'h0, unf_count}, 64'(m_unf));
        chk("inv_count", {48'h0, inv_count}, 64'(m_inv));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flags_clear = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_sticky = 3'b000;
`ifdef FPU_RESULT_STATS_EN
        m_ovf = 0; m_unf = 0; m_inv = 0;
`endif
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_sticky", {61'h0, sticky_flags}, 64'h0);
    endtask

    initial begin
        logic [63:0] r;
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0;
        in_underflow = 1'b0; out_ready = 1'b0; flags_clear = 1'b0;
        m_sticky = 3'b000;
        repeat (2) @(posedge clk);
        do_reset();
        chk("rst_out_result", out_result, 64'h0);
        chk("rst_out_flags", {61'h0, out_flags}, 64'h0);

        // Normal flow: 1.0 through, visible the next cycle.
        cycle(1, 64'h3FF0_0000_0000_0000, 0, 0, 1, 0);
        chk("norm_result", out_result, 64'h3FF0_0000_0000_0000);
        chk("norm_flags", {61'h0, out_flags}, 64'h0);
        cycle(0, 64'h0, 0, 0, 1, 0);

        // Negative overflow -> -Inf.
        cycle(1, 64'hBFF0_1234_0000_0000, 1, 0, 1, 0);
        chk("ovf_result", out_result, 64'hFFF0_0000_0000_0000);
        chk("ovf_flags", {61'h0, out_flags}, 64'h1);
        chk("ovf_sticky", {61'h0, sticky_flags}, 64'h1);
        cycle(0, 64'h0, 0, 0, 1, 1);

        // Underflow then NaN.
        cycle(1, 64'h0012_3456_789A_BCDE, 0, 1, 1, 0);
        chk("unf_result", out_result, 64'h0);
        chk("unf_flags", {61'h0, out_flags}, 64'h2);
        cycle(1, 64'h7FF8_0000_0000_0000, 0, 0, 1, 0);
        chk("nan_result", out_result, 64'h7FF8_0000_0000_0000);
        chk("nan_flags", {61'h0, out_flags}, 64'h4);
        chk("unf_nan_sticky", {61'h0, sticky_flags}, 64'h6);
        cycle(0, 64'h0, 0, 0, 1, 0);

        // Overflow and underflow together: Inf value, both flags.
        cycle(1, 64'h4000_0000_0000_0000, 1, 1, 1, 0);
        chk("both_result", out_result, 64'h7FF0_0000_0000_0000);
        chk("both_flags", {61'h0, out_flags}, 64'h3);
        cycle(0, 64'h0, 0, 0, 1, 0);

        // Backpressure: fill, third push ignored, then drain in order.
        cycle(1, 64'h1111_0000_0000_0001, 0, 0, 0, 0);
        cycle(1, 64'h2222_0000_0000_0002, 0, 0, 0, 0);
        chk("full_in_ready", {63'h0, in_ready}, 64'h0);
        cycle(1, 64'h3333_0000_0000_0003, 0, 0, 0, 0);
        chk("bp_head_A", out_result, 64'h1111_0000_0000_0001);
        cycle(0, 64'h0, 0, 0, 1, 0);
        chk("bp_ready_back", {63'h0, in_ready}, 64'h1);
        chk("bp_head_B", out_result, 64'h2222_0000_0000_0002);
        cycle(0, 64'h0, 0, 0, 1, 0);
        chk("bp_empty", {63'h0, out_valid}, 64'h0);

        // Clear coincident with an overflow push: set wins.
        cycle(1, 64'h3FF0_0000_0000_0000, 0, 1, 1, 0);
        cycle(1, 64'h3FF0_0000_0000_0000, 1, 0, 0, 1);
        chk("clr_set_sticky", {61'h0, sticky_flags}, 64'h1);
        chk("pre_rst_full", {63'h0, in_ready}, 64'h0);
        do_reset();

`ifdef FPU_RESULT_STATS_EN
        for (int i = 0; i < 3; i++) cycle(1, 64'h3FF0_0000_0000_0000, 1, 0, 1, 0);
        chk("stats_ovf3", {48'h0, ovf_count}, 64'h3);
        cycle(0, 64'h0, 0, 0, 1, 1);
        chk("stats_clr", {48'h0, ovf_count}, 64'h0);
        cycle(1, 64'h3FF0_0000_0000_0000, 1, 0, 1, 1);
        chk("stats_clr_inc", {48'h0, ovf_count}, 64'h1);
`endif

        // Random traffic with NaN/Inf-heavy operands.
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: r[62:52] = 11'h7FF;
                1: r[62:52] = 11'h000;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) r[51:0] = '0;
            cycle($urandom_range(0, 3) != 0, r,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
